// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Serial frame receiver. The raw line is synchronised first. A falling edge
// opens a start-bit check at mid-bit, so short glitches are rejected. After
// that the block samples DATA_BITS data bits (LSB first) at bit centres,
// optionally checks a parity bit, and checks STOP_BITS stop bits. It then
// presents the assembled word with one-cycle status pulses.
//
// Optional feature: define PARITY_CHECK_EN to add a parity bit between the
// data and stop bits. PARITY_ODD selects even (0) or odd (1) parity. Without
// the macro, the parity state and its logic are absent and parity_err_o is
// tied low.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   data_i         raw serial line, idle high, asynchronous to clk_i
//   init_o         pulse: frame start detected
//   recv_en_o      high while a frame is being received (not IDLE)
//   sample_o       pulse per data-bit sample
//   data_o         last good word, held until the next good frame
//   done_o         pulse: good frame received, data_o updated
//   false_start_o  pulse: start bit rejected at mid-bit
//   frame_err_o    pulse: a stop bit was sampled low
//   parity_err_o   pulse: parity mismatch (0 without PARITY_CHECK_EN)
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 data_i,
  output logic                 init_o,
  output logic                 recv_en_o,
  output logic                 sample_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 done_o,
  output logic                 false_start_o,
  output logic                 frame_err_o,
  output logic                 parity_err_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + STOP_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  // Refuse to elaborate with settings the bit timing cannot support.
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_rx_frame: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PARITY_CHECK_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic                 sync_1;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 half_end;
  logic                 bit_end;
  logic                 frame_bad;

  logic init_next;
  logic false_start_next;
  logic sample_next;
  logic stop_take;
  logic done_next;
  logic frame_err_next;

`ifdef PARITY_CHECK_EN
  localparam logic PARITY_SENSE = (PARITY_ODD != 0);
  logic par_bit;
  logic par_take;
  logic parity_bad;
  logic parity_err_next;

  // The XOR of data and parity bit must equal the selected sense.
  assign parity_bad = ((^shreg) ^ par_bit) != PARITY_SENSE;
`endif

  assign half_end  = (cnt == HALF_LAST);
  assign bit_end   = (cnt == FULL_LAST);
  assign recv_en_o = (state != IDLE);

  // Two-flop synchroniser. Both flops reset to the idle line level, so that
  // leaving reset is not mistaken for a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= data_i;
      rx_s   <= sync_1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the pulse values to register on this edge. The
  // last stop sample returns to IDLE at the bit centre. This leaves half a bit
  // to catch a start bit that follows immediately.
  always_comb begin
    state_next       = state;
    init_next        = 1'b0;
    false_start_next = 1'b0;
    sample_next      = 1'b0;
    stop_take        = 1'b0;
    done_next        = 1'b0;
    frame_err_next   = 1'b0;
    frame_bad        = 1'b0;
`ifdef PARITY_CHECK_EN
    par_take         = 1'b0;
    parity_err_next  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          init_next  = 1'b1;
        end
      end
      START: begin
        if (half_end) begin
          if (rx_s) begin
            state_next       = IDLE;
            false_start_next = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          sample_next = 1'b1;
          if (bit_cnt == DATA_LAST) begin
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bit_end) begin
          par_take   = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          stop_take = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            state_next = IDLE;
            frame_bad  = stop_err | ~rx_s;
            frame_err_next = frame_bad;
`ifdef PARITY_CHECK_EN
            parity_err_next = parity_bad;
            done_next       = ~frame_bad & ~parity_bad;
`else
            done_next       = ~frame_bad;
`endif
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. The cycle counter restarts on every state change, so each
  // state measures its sample point from its own entry edge. bit_cnt counts
  // the data samples in DATA and the stop samples in STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt           <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      stop_err      <= 1'b0;
      data_o        <= '0;
      init_o        <= 1'b0;
      sample_o      <= 1'b0;
      done_o        <= 1'b0;
      false_start_o <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      if (state_next != state || state == IDLE || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (sample_next || stop_take) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (sample_next) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end

      if (state_next != state) begin
        stop_err <= 1'b0;
      end else if (stop_take && !rx_s) begin
        stop_err <= 1'b1;
      end

      if (done_next) begin
        data_o <= shreg;
      end

      init_o        <= init_next;
      sample_o      <= sample_next;
      done_o        <= done_next;
      false_start_o <= false_start_next;
      frame_err_o   <= frame_err_next;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity bit capture and its error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (par_take) begin
        par_bit <= rx_s;
      end
      parity_err_o <= parity_err_next;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
